pcie_tx_arb: RTL and testbench
==============================

# pcie_tx_arb

Two-requester arbiter that shares the single VC0 transmit port of the PCIe core between a posted-write source (req 0) and a completion source (req 1). It sits between the ipnuma user logic and the pcie_top transmit interface. It gates each grant on available transmit credits, runs the tx_req/tx_rdy handshake with the core, and muxes the granted requester's TLP stream onto tx_st/tx_end/tx_data. Service order is round-robin.

## Interface
- DW, 16, TLP data width; matches tx_data
- CNT_W, 16, width of the per-requester packet counters
- pcie_clk  in  1  125 MHz PCIe user clock; the only clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- req_valid[1:0]  in  2  requester i has a complete TLP ready; held until its tx_end is accepted
- req_ph[1:0]  in  2  header credits needed (0 or 1)
- req_pd0, req_pd1  in  9 each  data credits needed (16-byte units)
- req_gnt[1:0]  out  2  one-hot; high from the grant until the cycle after tx_end
- req_st[1:0], req_end[1:0]  in  2 each  requester start/end strobes
- req_data0, req_data1  in  DW each  requester data
- tx_req  out  1  to core
- tx_rdy  in  1  from core
- tx_st, tx_end  out  1 each  to core
- tx_data  out  DW  to core
- tx_ca_ph, tx_ca_cplh  in  9 each  core header credits; bit 8 = infinite
- tx_ca_pd, tx_ca_cpld  in  13 each  core data credits; bit 12 = infinite
- tx_ca_p_recheck, tx_ca_cpl_recheck  in  1 each  credit values are being updated
- pkt_cnt0, pkt_cnt1  out  CNT_W each  completed TLPs per requester; wrap at 2^CNT_W
- busy  out  1  state is not IDLE

## Operation
- States: IDLE, CHECK, REQ, XFER.
- IDLE: if any req_valid is set, pick the winner and latch it in sel, then go to CHECK.
  - Round-robin: if both are valid, pick the one not equal to last.
  - last resets to 1, so req 0 wins first.
- CHECK: the credit test uses the winner's class (req 0 uses ph/pd, req 1 uses cplh/cpld).
  - Pass if (infinite bit set OR avail ≥ need) for both the header and the data credit.
  - If the matching recheck input is high, the test is not evaluated; stay in CHECK.
  - Pass → REQ, assert tx_req. Fail → stay in CHECK; there is no re-arbitration while blocked (head-of-line is intentional).
- REQ: hold tx_req until tx_rdy = 1.
  - In the tx_rdy cycle: deassert tx_req, assert req_gnt[sel], go to XFER.
- XFER: tx_st/tx_end/tx_data = req_st/req_end/req_data of sel (combinational mux). Non-selected inputs are ignored.
  - On tx_end: pkt_cnt[sel]++, last ← sel, req_gnt ← 0, go to IDLE.
- When nothing is granted, tx_st, tx_end and tx_data are 0.
- A requester dropping req_valid after CHECK does not abort the sequence; the transfer completes only on its tx_end.
- Reset value of every output: 0.
  - Async reset mid-XFER returns to IDLE immediately with tx_req = 0 and gnt = 0.
  - The core is reset by the same sys_rst_n, so no partial-TLP cleanup is performed.

## Timing
- Minimum latency from req_valid to tx_req: 2 cycles (IDLE→CHECK, CHECK→REQ). tx_req is registered.
- req_gnt rises in the cycle after tx_rdy is sampled high.
- The requester drives req_st in the first grant cycle, so tx_st appears on the cycle after tx_rdy.
- Data path through the block: 0 cycles.
- Back-to-back TLPs: the next tx_req appears no earlier than 2 cycles after tx_end.
- A single-cycle TLP (st and end in the same cycle) is legal.
- tx_rdy outside REQ is ignored.

## Structure
- Shared package pcie_tx_pkg holds:
  - state encoding;
  - REQ_P = 0, REQ_CPL = 1;
  - credit infinite-bit positions (8, 12).
- One sub-module, pcie_credit_chk: combinational pass/fail from (hdr_avail, data_avail, need_h, need_d, recheck).
- Counters, FSM and mux stay in pcie_tx_arb (about 200 RTL lines).

## Test plan
- Single requester: req_valid0 = 1, ph = 1, pd = 4, tx_ca_ph = 8, tx_ca_pd = 32, tx_rdy 3 cycles after tx_req → tx_req 2 cycles after valid, gnt0 the cycle after tx_rdy, 6-beat TLP forwarded unchanged, pkt_cnt0 = 1.
- Both valid continuously → grant order 0,1,0,1; pkt_cnt0 = pkt_cnt1 = 2 after 4 TLPs.
- Credit block: tx_ca_cpld = 2, req_pd1 = 4 → stays in CHECK with no tx_req; raise cpld to 4 → tx_req the next cycle. tx_ca_cpld = 13'h1000 (infinite) → passes.
- Recheck: tx_ca_p_recheck held 3 cycles with sufficient credits → tx_req is delayed until the cycle after recheck falls.
- Async reset during XFER beat 3 → tx_req, tx_st, gnt, busy and pkt_cnt are all 0 in the same cycle. After release with both valid, req 0 is granted first.
- Counter wrap: pkt_cnt0 preloaded by running 2^CNT_W TLPs (CNT_W = 4 in the bench) → wraps to 0.

Source files
------------

// File: rtl/pcie_tx_pkg.sv
// Shared types and constants for the PCIe VC0 transmit arbiter.
// Covers the state encoding, requester indices and the credit field layout.
package pcie_tx_pkg;

    localparam int unsigned REQ_P        = 0;
    localparam int unsigned REQ_CPL      = 1;

    localparam int unsigned HDR_CW       = 9;
    localparam int unsigned DATA_CW      = 13;
    localparam int unsigned PD_W         = 9;
    localparam int unsigned HDR_INF_BIT  = 8;
    localparam int unsigned DATA_INF_BIT = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_REQ   = 2'd2,
        ST_XFER  = 2'd3
    } state_e;

    // Credits advertised by the core for one traffic class.
    typedef struct packed {
        logic [HDR_CW-1:0]  hdr;
        logic [DATA_CW-1:0] data;
        logic               recheck;
    } credit_t;

    // Credits a pending TLP needs.
    typedef struct packed {
        logic            need_h;
        logic [PD_W-1:0] need_d;
    } need_t;

endpackage

// File: rtl/pcie_credit_chk.sv
// Combinational credit test: a TLP may go when both the header and data credits
// are infinite or sufficient, and the core is not in the middle of updating them.
module pcie_credit_chk
    import pcie_tx_pkg::*;
(
    input  logic [HDR_CW-1:0]  hdr_avail_i,
    input  logic [DATA_CW-1:0] data_avail_i,
    input  logic               need_h_i,
    input  logic [PD_W-1:0]    need_d_i,
    input  logic               recheck_i,
    output logic               pass_o
);

    logic hdr_ok_c;
    logic data_ok_c;

    assign hdr_ok_c  = hdr_avail_i[HDR_INF_BIT] ||
                       (hdr_avail_i[HDR_INF_BIT-1:0] >= HDR_INF_BIT'(need_h_i));
    assign data_ok_c = data_avail_i[DATA_INF_BIT] ||
                       (data_avail_i[DATA_INF_BIT-1:0] >= DATA_INF_BIT'(need_d_i));

    assign pass_o = !recheck_i && hdr_ok_c && data_ok_c;

endmodule

// File: rtl/pcie_tx_arb.sv
// Round-robin arbiter sharing the PCIe VC0 transmit port between a posted-write
// source (req 0) and a completion source (req 1), gated on transmit credits.
module pcie_tx_arb
    import pcie_tx_pkg::*;
#(
    parameter int unsigned DW    = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic                pcie_clk,
    input  logic                sys_rst_n,

    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_ph,
    input  logic [PD_W-1:0]     req_pd0,
    input  logic [PD_W-1:0]     req_pd1,
    output logic [1:0]          req_gnt,
    input  logic [1:0]          req_st,
    input  logic [1:0]          req_end,
    input  logic [DW-1:0]       req_data0,
    input  logic [DW-1:0]       req_data1,

    output logic                tx_req,
    input  logic                tx_rdy,
    output logic                tx_st,
    output logic                tx_end,
    output logic [DW-1:0]       tx_data,

    input  logic [HDR_CW-1:0]   tx_ca_ph,
    input  logic [HDR_CW-1:0]   tx_ca_cplh,
    input  logic [DATA_CW-1:0]  tx_ca_pd,
    input  logic [DATA_CW-1:0]  tx_ca_cpld,
    input  logic                tx_ca_p_recheck,
    input  logic                tx_ca_cpl_recheck,

    output logic [CNT_W-1:0]    pkt_cnt0,
    output logic [CNT_W-1:0]    pkt_cnt1,
    output logic                busy
);

    state_e           state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_q, last_d;
    logic             tx_req_q, tx_req_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    credit_t          cred_c;
    need_t            need_c;
    logic             pass_c;
    logic             xfer_end_c;
    logic [DW-1:0]    tx_data_c;

    // Select the credit class and requirement of the latched winner.
    always_comb begin
        cred_c.hdr     = tx_ca_ph;
        cred_c.data    = tx_ca_pd;
        cred_c.recheck = tx_ca_p_recheck;
        need_c.need_h  = req_ph[REQ_P];
        need_c.need_d  = req_pd0;
        if (sel_q) begin
            cred_c.hdr     = tx_ca_cplh;
            cred_c.data    = tx_ca_cpld;
            cred_c.recheck = tx_ca_cpl_recheck;
            need_c.need_h  = req_ph[REQ_CPL];
            need_c.need_d  = req_pd1;
        end
    end

    pcie_credit_chk u_credit_chk (
        .hdr_avail_i  (cred_c.hdr),
        .data_avail_i (cred_c.data),
        .need_h_i     (need_c.need_h),
        .need_d_i     (need_c.need_d),
        .recheck_i    (cred_c.recheck),
        .pass_o       (pass_c)
    );

    // Zero-latency data path; the grant register doubles as the mux select.
    always_comb begin
        tx_data_c = '0;
        if (gnt_q[REQ_P]) begin
            tx_data_c = req_data0;
        end else if (gnt_q[REQ_CPL]) begin
            tx_data_c = req_data1;
        end
    end

    assign xfer_end_c = |(gnt_q & req_end);

    // Next-state logic; a blocked winner stays in CHECK without re-arbitration.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        last_d   = last_q;
        tx_req_d = tx_req_q;
        gnt_d    = gnt_q;
        cnt0_d   = cnt0_q;
        cnt1_d   = cnt1_q;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    if (&req_valid) begin
                        sel_d = ~last_q;
                    end else begin
                        sel_d = req_valid[REQ_CPL];
                    end
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (pass_c) begin
                    tx_req_d = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (tx_rdy) begin
                    tx_req_d     = 1'b0;
                    gnt_d        = '0;
                    gnt_d[sel_q] = 1'b1;
                    state_d      = ST_XFER;
                end
            end
            ST_XFER: begin
                if (xfer_end_c) begin
                    if (sel_q) begin
                        cnt1_d = cnt1_q + CNT_W'(1);
                    end else begin
                        cnt0_d = cnt0_q + CNT_W'(1);
                    end
                    last_d  = sel_q;
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // last starts at the completion side so the posted source wins first.
    always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= 1'b0;
            last_q   <= 1'(REQ_CPL);
            tx_req_q <= 1'b0;
            gnt_q    <= '0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            tx_req_q <= tx_req_d;
            gnt_q    <= gnt_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
        end
    end

    assign req_gnt  = gnt_q;
    assign tx_req   = tx_req_q;
    assign tx_st    = |(gnt_q & req_st);
    assign tx_end   = xfer_end_c;
    assign tx_data  = tx_data_c;
    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pcie_tx_arb.sv
// Directed bench for pcie_tx_arb: requester and core models drive the DUT,
// while beat and grant-order scoreboards check the forwarded TLP stream.
module tb_pcie_tx_arb;

    localparam int unsigned DW    = 16;
    localparam int unsigned CNT_W = 4;

    logic              pcie_clk = 1'b0;
    logic              sys_rst_n;
    logic [1:0]        req_valid, req_ph, req_gnt, req_st, req_end;
    logic [8:0]        req_pd0, req_pd1;
    logic [DW-1:0]     req_data0, req_data1, tx_data;
    logic              tx_req, tx_rdy, tx_st, tx_end;
    logic [8:0]        tx_ca_ph, tx_ca_cplh;
    logic [12:0]       tx_ca_pd, tx_ca_cpld;
    logic              tx_ca_p_recheck, tx_ca_cpl_recheck;
    logic [CNT_W-1:0]  pkt_cnt0, pkt_cnt1;
    logic              busy;

    pcie_tx_arb #(.DW(DW), .CNT_W(CNT_W)) dut (
        .pcie_clk          (pcie_clk),
        .sys_rst_n         (sys_rst_n),
        .req_valid         (req_valid),
        .req_ph            (req_ph),
        .req_pd0           (req_pd0),
        .req_pd1           (req_pd1),
        .req_gnt           (req_gnt),
        .req_st            (req_st),
        .req_end           (req_end),
        .req_data0         (req_data0),
        .req_data1         (req_data1),
        .tx_req            (tx_req),
        .tx_rdy            (tx_rdy),
        .tx_st             (tx_st),
        .tx_end            (tx_end),
        .tx_data           (tx_data),
        .tx_ca_ph          (tx_ca_ph),
        .tx_ca_cplh        (tx_ca_cplh),
        .tx_ca_pd          (tx_ca_pd),
        .tx_ca_cpld        (tx_ca_cpld),
        .tx_ca_p_recheck   (tx_ca_p_recheck),
        .tx_ca_cpl_recheck (tx_ca_cpl_recheck),
        .pkt_cnt0          (pkt_cnt0),
        .pkt_cnt1          (pkt_cnt1),
        .busy              (busy)
    );

    always #5 pcie_clk = ~pcie_clk;

    typedef struct packed {
        logic          st;
        logic          en;
        logic [DW-1:0] data;
    } beat_t;

    beat_t            exp_beats[$];
    int               exp_gnt[$];
    int               checks = 0;
    int               errors = 0;
    int               pend[2];
    int               len[2];
    int               bidx[2];
    logic [CNT_W-1:0] exp_cnt[2];
    int               rdy_dly;
    int               age;
    logic             spur_rdy;
    logic             prev_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        pend      = '{0, 0};
        bidx      = '{0, 0};
        exp_cnt   = '{CNT_W'(0), CNT_W'(0)};
        exp_beats.delete();
        exp_gnt.delete();
        age       = 0;
        prev_rdy  = 1'b0;
        tx_rdy    = 1'b0;
        req_valid = 2'b00;
        req_st    = 2'b00;
        req_end   = 2'b00;
        req_data0 = '0;
        req_data1 = '0;
    endtask

    task automatic hold_reset();
        sys_rst_n = 1'b0;
        clear_model();
        repeat (2) @(posedge pcie_clk);
        #3;
        sys_rst_n = 1'b1;
    endtask

    // One clock cycle: drive requester/core models, then check the TLP stream.
    task automatic step();
        beat_t b;
        beat_t e;
        @(posedge pcie_clk);
        #1;
        if (prev_rdy) begin
            chk("gnt_after_rdy", 32'(|req_gnt), 32'd1);
            chk("req_drop_after_rdy", 32'(tx_req), 32'd0);
        end
        chk("gnt_onehot", 32'(req_gnt == 2'b11), 32'd0);

        req_valid = {(pend[1] != 0), (pend[0] != 0)};
        if (tx_req) begin
            tx_rdy = (age == rdy_dly);
            age++;
        end else begin
            tx_rdy = spur_rdy;
            age    = 0;
        end
        prev_rdy = tx_req && tx_rdy;

        req_st    = 2'($urandom);
        req_end   = 2'($urandom);
        req_data0 = DW'($urandom);
        req_data1 = DW'($urandom);
        for (int i = 0; i < 2; i++) begin
            if (req_gnt[i]) begin
                if (bidx[i] == 0) begin
                    if (exp_gnt.size() == 0) chk("gnt_unexpected", 32'(i), 32'hff);
                    else chk("gnt_order", 32'(i), 32'(exp_gnt.pop_front()));
                end
                b.st   = (bidx[i] == 0);
                b.en   = (bidx[i] == len[i] - 1);
                b.data = DW'($urandom);
                req_st[i]  = b.st;
                req_end[i] = b.en;
                if (i == 0) req_data0 = b.data;
                else        req_data1 = b.data;
                exp_beats.push_back(b);
                bidx[i]++;
                if (b.en) begin
                    bidx[i] = 0;
                    pend[i]--;
                    exp_cnt[i] = exp_cnt[i] + CNT_W'(1);
                end
            end
        end

        #1;
        if (|req_gnt) begin
            if (exp_beats.size() == 0) begin
                chk("beat_unexpected", 32'(tx_st), 32'hff);
            end else begin
                e = exp_beats.pop_front();
                chk("tx_st", 32'(tx_st), 32'(e.st));
                chk("tx_end", 32'(tx_end), 32'(e.en));
                chk("tx_data", 32'(tx_data), 32'(e.data));
            end
        end else begin
            chk("idle_tx_zero", 32'({tx_st, tx_end, tx_data}), 32'd0);
        end
    endtask

    task automatic run_idle(input string tag, input int max);
        int n;
        n = 0;
        while ((pend[0] != 0 || pend[1] != 0 || busy) && n < max) begin
            step();
            n++;
        end
        chk(tag, 32'(n < max), 32'd1);
        chk("cnt0_model", 32'(pkt_cnt0), 32'(exp_cnt[0]));
        chk("cnt1_model", 32'(pkt_cnt1), 32'(exp_cnt[1]));
        chk("gnt_order_left", 32'(exp_gnt.size()), 32'd0);
    endtask

    initial begin
        int n;
        sys_rst_n         = 1'b0;
        req_ph            = 2'b11;
        req_pd0           = 9'd4;
        req_pd1           = 9'd4;
        tx_ca_ph          = 9'd8;
        tx_ca_pd          = 13'd32;
        tx_ca_cplh        = 9'd8;
        tx_ca_cpld        = 13'd64;
        tx_ca_p_recheck   = 1'b0;
        tx_ca_cpl_recheck = 1'b0;
        spur_rdy          = 1'b0;
        rdy_dly           = 0;
        len               = '{1, 1};
        clear_model();
        #12;
        chk("rst_tx_req", 32'(tx_req), 32'd0);
        chk("rst_gnt", 32'(req_gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'({pkt_cnt0, pkt_cnt1}), 32'd0);
        chk("rst_tx", 32'({tx_st, tx_end, tx_data}), 32'd0);
        sys_rst_n = 1'b1;

        // Single requester, 6-beat TLP, core ready 3 cycles after tx_req.
        len[0]  = 6;
        pend[0] = 1;
        rdy_dly = 3;
        exp_gnt.push_back(0);
        step();
        chk("t1_idle_req", 32'(tx_req), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        step();
        chk("t1_check_req", 32'(tx_req), 32'd0);
        chk("t1_check_busy", 32'(busy), 32'd1);
        step();
        chk("t1_req_latency", 32'(tx_req), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_req_hold", 32'(tx_req), 32'd1);
            chk("t1_no_gnt", 32'(req_gnt), 32'd0);
        end
        step();
        chk("t1_gnt0", 32'(req_gnt), 32'd1);
        chk("t1_first_st", 32'(tx_st), 32'd1);
        run_idle("t1_done", 40);
        chk("t1_cnt0", 32'(pkt_cnt0), 32'd1);
        rdy_dly = 1;

        // Both requesters continuously valid: strict alternation from reset.
        hold_reset();
        len  = '{3, 1};
        pend = '{2, 2};
        exp_gnt.push_back(0);
        exp_gnt.push_back(1);
        exp_gnt.push_back(0);
        exp_gnt.push_back(1);
        run_idle("t2_done", 200);
        chk("t2_cnt0", 32'(pkt_cnt0), 32'd2);
        chk("t2_cnt1", 32'(pkt_cnt1), 32'd2);

        // Completion blocked on data credits; spurious tx_rdy must be ignored.
        tx_ca_cpld = 13'd2;
        len[1]     = 4;
        pend[1]    = 1;
        spur_rdy   = 1'b1;
        exp_gnt.push_back(1);
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_blocked_req", 32'(tx_req), 32'd0);
            chk("t3_blocked_busy", 32'(busy), 32'd1);
            chk("t3_blocked_gnt", 32'(req_gnt), 32'd0);
        end
        tx_ca_cpld = 13'd4;
        step();
        chk("t3_unblock_req", 32'(tx_req), 32'd1);
        spur_rdy = 1'b0;
        run_idle("t3_done", 40);
        chk("t3_cnt1", 32'(pkt_cnt1), 32'd3);

        // Infinite data credit passes regardless of the finite field.
        tx_ca_cpld = 13'h1000;
        req_pd1    = 9'd300;
        len[1]     = 2;
        pend[1]    = 1;
        exp_gnt.push_back(1);
        step();
        step();
        step();
        chk("t3_inf_req", 32'(tx_req), 32'd1);
        run_idle("t3_inf_done", 40);
        chk("t3_inf_cnt1", 32'(pkt_cnt1), 32'd4);

        // Posted recheck held 3 cycles; completion recheck must not matter.
        tx_ca_p_recheck   = 1'b1;
        tx_ca_cpl_recheck = 1'b1;
        len[0]  = 2;
        pend[0] = 1;
        exp_gnt.push_back(0);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_recheck_req", 32'(tx_req), 32'd0);
        end
        tx_ca_p_recheck = 1'b0;
        step();
        chk("t4_release_req", 32'(tx_req), 32'd1);
        run_idle("t4_done", 40);
        tx_ca_cpl_recheck = 1'b0;
        chk("t4_cnt0", 32'(pkt_cnt0), 32'd3);

        // Async reset during the third beat of a transfer.
        rdy_dly = 0;
        len[0]  = 6;
        pend[0] = 1;
        exp_gnt.push_back(0);
        n = 0;
        while (!(req_gnt[0] && bidx[0] == 3) && n < 30) begin
            step();
            n++;
        end
        chk("t5_reach_beat3", 32'(n < 30), 32'd1);
        sys_rst_n = 1'b0;
        #1;
        chk("t5_rst_tx_req", 32'(tx_req), 32'd0);
        chk("t5_rst_tx_st", 32'(tx_st), 32'd0);
        chk("t5_rst_tx_data", 32'(tx_data), 32'd0);
        chk("t5_rst_gnt", 32'(req_gnt), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_cnt", 32'({pkt_cnt0, pkt_cnt1}), 32'd0);
        hold_reset();
        len  = '{2, 2};
        pend = '{1, 1};
        exp_gnt.push_back(0);
        exp_gnt.push_back(1);
        run_idle("t5_done", 60);

        // Counter wrap: single-cycle TLPs take pkt_cnt0 to 2^CNT_W.
        len[0]  = 1;
        pend[0] = (1 << CNT_W) - int'(exp_cnt[0]);
        for (int i = 0; i < pend[0]; i++) exp_gnt.push_back(0);
        run_idle("t6_done", 400);
        chk("t6_cnt0_wrap", 32'(pkt_cnt0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
